// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] FETCH_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry instruction buffer between the fetch FSM and the IF/ID register.
// Flush beats load, load beats consume; outputs read as a NOP bubble when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            consume,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc4,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc4_d   = load_pc4;
      instr_d = load_instr;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc4   = valid_q ? pc4_q : '0;
  assign instr = valid_q ? instr_q : NOP_INSTR;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, one-outstanding fetch FSM, redirect/discard handling.
// Define FETCH_PERF_COUNT_EN to add the FetchCount/BubbleCount performance counters.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectTarget,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemReady,
  input  logic            ImemValid,
  input  logic [XLEN-1:0] ImemData,
  output logic            IFValid,
  output logic [XLEN-1:0] IFInstruction,
  output logic [XLEN-1:0] IFPCplus4
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [XLEN-1:0] FetchCount,
  output logic [XLEN-1:0] BubbleCount
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            discard_q, discard_d;
  logic            buf_load, buf_consume, buf_flush;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    ImemReq     = 1'b0;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    buf_flush   = 1'b0;

    if (Redirect) begin
      pc_d      = RedirectTarget;
      buf_flush = 1'b1;
      if (state_q == FS_WAIT) begin
        // The in-flight response belongs to the wrong path: drop it now or mark it.
        if (ImemValid) begin
          discard_d = 1'b0;
          state_d   = FS_REQ;
        end else begin
          discard_d = 1'b1;
        end
      end else begin
        state_d = FS_REQ;
      end
    end else begin
      case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ: begin
          ImemReq = 1'b1;
          if (ImemReady) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (ImemValid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = FS_REQ;
            end else begin
              buf_load = 1'b1;
              state_d  = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          // Next fetch goes out in the same cycle the buffered instruction is taken.
          if (!Stall) begin
            buf_consume = 1'b1;
            ImemReq     = 1'b1;
            if (ImemReady) begin
              req_pc_d = pc_q;
              pc_d     = pc_q + 32'd4;
              state_d  = FS_WAIT;
            end else begin
              state_d = FS_REQ;
            end
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= FS_IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
    end
  end

  assign ImemAddr = ImemReq ? pc_q : '0;

  fetch_buffer #(
    .NOP_INSTR(NOP_INSTR)
  ) u_buffer (
    .clk       (Clk),
    .rst       (Reset),
    .load      (buf_load),
    .consume   (buf_consume),
    .flush     (buf_flush),
    .load_pc4  (req_pc_q + 32'd4),
    .load_instr(ImemData),
    .valid     (IFValid),
    .pc4       (IFPCplus4),
    .instr     (IFInstruction)
  );

`ifdef FETCH_PERF_COUNT_EN
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (buf_consume) fetch_count_d = fetch_count_q + 32'd1;
    if (!Stall && !IFValid) bubble_count_d = bubble_count_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign FetchCount  = fetch_count_q;
  assign BubbleCount = bubble_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small latency-configurable instruction memory model.
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic        IFValid;
  logic [31:0] IFInstruction;
  logic [31:0] IFPCplus4;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  int          testsRun = 0;
  int          testsFailed = 0;
  int          memLatency = 1;
  int          pendCnt = 0;
  logic [31:0] pendAddr = '0;

  if_fetch_unit dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Redirect      (Redirect),
    .RedirectTarget(RedirectTarget),
    .ImemReq       (ImemReq),
    .ImemAddr      (ImemAddr),
    .ImemReady     (ImemReady),
    .ImemValid     (ImemValid),
    .ImemData      (ImemData),
    .IFValid       (IFValid),
    .IFInstruction (IFInstruction),
    .IFPCplus4     (IFPCplus4)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .FetchCount    (FetchCount),
    .BubbleCount   (BubbleCount)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; the memory accepts what the DUT requests and answers memLatency cycles later.
  task automatic applyStimulus();
    logic        acc;
    logic [31:0] accAddr;
    #1;
    acc     = ImemReq && ImemReady;
    accAddr = ImemAddr;
    @(posedge Clk);
    #1;
    ImemValid = 1'b0;
    if (acc) begin
      pendCnt  = memLatency;
      pendAddr = accAddr;
    end
    if (pendCnt > 0) begin
      pendCnt--;
      if (pendCnt == 0) begin
        ImemValid = 1'b1;
        ImemData  = instrOf(pendAddr);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = '0;
    ImemReady = 1'b1; ImemValid = 1'b0; ImemData = '0;

    #2;
    checkOutput("rst_req", {31'b0, ImemReq}, 32'd0);
    checkOutput("rst_addr", ImemAddr, 32'd0);
    checkOutput("rst_valid", {31'b0, IFValid}, 32'd0);
    checkOutput("rst_instr", IFInstruction, 32'd0);
    checkOutput("rst_pc4", IFPCplus4, 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    checkOutput("idle_req", {31'b0, ImemReq}, 32'd0);

    // Zero-wait memory, no stalls: addresses 0,4,8,12 and alternating IFValid
    applyStimulus();
    checkOutput("req0_req", {31'b0, ImemReq}, 32'd1);
    checkOutput("req0_addr", ImemAddr, 32'd0);
    applyStimulus();
    checkOutput("wait0_valid", {31'b0, IFValid}, 32'd0);
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      checkOutput("zw_valid", {31'b0, IFValid}, 32'd1);
      checkOutput("zw_instr", IFInstruction, instrOf(32'(4 * i)));
      checkOutput("zw_pc4", IFPCplus4, 32'(4 * i + 4));
      checkOutput("zw_next_req", {31'b0, ImemReq}, 32'd1);
      checkOutput("zw_next_addr", ImemAddr, 32'(4 * i + 4));
      applyStimulus();
      checkOutput("zw_bubble", {31'b0, IFValid}, 32'd0);
      applyStimulus();
    end
    checkOutput("zw3_pc4", IFPCplus4, 32'd16);

    // Stall in HOLD for 4 cycles
    Stall = 1'b1;
    #1;
    checkOutput("stall_noreq", {31'b0, ImemReq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("stall_valid", {31'b0, IFValid}, 32'd1);
      checkOutput("stall_instr", IFInstruction, instrOf(32'd12));
      checkOutput("stall_pc4", IFPCplus4, 32'd16);
      checkOutput("stall_req", {31'b0, ImemReq}, 32'd0);
    end
    Stall = 1'b0;
    #1;
    checkOutput("unstall_req", {31'b0, ImemReq}, 32'd1);
    checkOutput("unstall_addr", ImemAddr, 32'd16);
    applyStimulus();
    checkOutput("unstall_bubble", {31'b0, IFValid}, 32'd0);
    applyStimulus();
    checkOutput("unstall_instr", IFInstruction, instrOf(32'd16));
    checkOutput("unstall_pc4", IFPCplus4, 32'd20);

    // Ready low for 3 cycles in REQ: address held, PC frozen
    ImemReady = 1'b0;
    applyStimulus();
    checkOutput("nordy_valid", {31'b0, IFValid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("nordy_req", {31'b0, ImemReq}, 32'd1);
      checkOutput("nordy_addr", ImemAddr, 32'd20);
      applyStimulus();
    end
    ImemReady = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("nordy_instr", IFInstruction, instrOf(32'd20));
    checkOutput("nordy_pc4", IFPCplus4, 32'd24);

    // Redirect in WAIT, response arrives a cycle after the redirect
    memLatency = 2;
    applyStimulus();
    Redirect = 1'b1; RedirectTarget = 32'h100;
    #1;
    checkOutput("rdw_req", {31'b0, ImemReq}, 32'd0);
    applyStimulus();
    Redirect = 1'b0;
    #1;
    checkOutput("rdw_valid0", {31'b0, IFValid}, 32'd0);
    checkOutput("rdw_still_wait", {31'b0, ImemReq}, 32'd0);
    applyStimulus();
    checkOutput("rdw_dropped", {31'b0, IFValid}, 32'd0);
    checkOutput("rdw_req_new", {31'b0, ImemReq}, 32'd1);
    checkOutput("rdw_addr_new", ImemAddr, 32'h100);
    memLatency = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("rdw_instr", IFInstruction, instrOf(32'h100));
    checkOutput("rdw_pc4", IFPCplus4, 32'h104);

    // Redirect in the same cycle as the response
    applyStimulus();
    Redirect = 1'b1; RedirectTarget = 32'h200;
    #1;
    checkOutput("rdv_req", {31'b0, ImemReq}, 32'd0);
    applyStimulus();
    Redirect = 1'b0;
    #1;
    checkOutput("rdv_dropped", {31'b0, IFValid}, 32'd0);
    checkOutput("rdv_req_new", {31'b0, ImemReq}, 32'd1);
    checkOutput("rdv_addr_new", ImemAddr, 32'h200);
    applyStimulus();
    applyStimulus();
    checkOutput("rdv_valid", {31'b0, IFValid}, 32'd1);
    checkOutput("rdv_instr", IFInstruction, instrOf(32'h200));
    checkOutput("rdv_pc4", IFPCplus4, 32'h204);

    // Redirect while stalled flushes the buffer
    Stall = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h300;
    #1;
    checkOutput("rds_req", {31'b0, ImemReq}, 32'd0);
    applyStimulus();
    Redirect = 1'b0; Stall = 1'b0;
    #1;
    checkOutput("rds_valid", {31'b0, IFValid}, 32'd0);
    checkOutput("rds_nop", IFInstruction, 32'd0);
    checkOutput("rds_pc4", IFPCplus4, 32'd0);
    checkOutput("rds_addr", ImemAddr, 32'h300);
    applyStimulus();
    applyStimulus();
    checkOutput("rds_instr", IFInstruction, instrOf(32'h300));
    checkOutput("rds_pc4_new", IFPCplus4, 32'h304);

    // PC wraps at the top of the address space
    Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
    applyStimulus();
    Redirect = 1'b0;
    #1;
    checkOutput("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
    applyStimulus();
    applyStimulus();
    checkOutput("wrap_valid", {31'b0, IFValid}, 32'd1);
    checkOutput("wrap_instr", IFInstruction, instrOf(32'hFFFF_FFFC));
    checkOutput("wrap_pc4", IFPCplus4, 32'd0);
    checkOutput("wrap_next_addr", ImemAddr, 32'd0);

    // Reset in WAIT, stale response arrives after release
    memLatency = 3;
    applyStimulus();
    Reset = 1'b1; ImemReady = 1'b0;
    #1;
    checkOutput("mrst_req", {31'b0, ImemReq}, 32'd0);
    checkOutput("mrst_valid", {31'b0, IFValid}, 32'd0);
    applyStimulus();
    Reset = 1'b0;
    #1;
`ifdef FETCH_PERF_COUNT_EN
    checkOutput("mrst_fetch_cnt", FetchCount, 32'd0);
    checkOutput("mrst_bubble_cnt", BubbleCount, 32'd0);
`endif
    applyStimulus();
    checkOutput("stale_seen", {31'b0, ImemValid}, 32'd1);
    checkOutput("stale_req", {31'b0, ImemReq}, 32'd1);
    checkOutput("stale_addr", ImemAddr, 32'd0);
    checkOutput("stale_valid", {31'b0, IFValid}, 32'd0);
    applyStimulus();
    checkOutput("stale_ignored", {31'b0, IFValid}, 32'd0);
    checkOutput("stale_req2", {31'b0, ImemReq}, 32'd1);
    ImemReady = 1'b1; memLatency = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("post_rst_valid", {31'b0, IFValid}, 32'd1);
    checkOutput("post_rst_instr", IFInstruction, instrOf(32'd0));
    checkOutput("post_rst_pc4", IFPCplus4, 32'd4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
